// File: rtl/pipe_reg_slice_pkg.sv
// Shared types and sizing helpers for the pipeline register slice.
// Defining PIPE_SKID_EN selects the skid-buffered stage, which doubles per-stage capacity.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

`ifdef PIPE_SKID_EN
  localparam int ENTRIES_PER_STAGE = 2;
`else
  localparam int ENTRIES_PER_STAGE = 1;
`endif

  function automatic int calcCntW(input int cap);
    return $clog2(cap + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_slice_stage.sv
// One valid/ready register stage with synchronous flush.
// With PIPE_SKID_EN a skid register breaks the ready path; otherwise ready is combinational.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ready_i
);

`ifdef PIPE_SKID_EN

  stage_state_t     state_q;
  logic             ready_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             drain;

  assign accept  = valid_i && ready_q && !flush_i;
  assign drain   = (state_q != EMPTY) && ready_i;
  assign ready_o = ready_q;
  assign valid_o = (state_q != EMPTY);
  assign data_o  = main_q;

  // ready_q mirrors (state != FULL) but lives in a flop so upstream never sees out_ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush_i) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_q  <= data_i;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (accept && drain) begin
            main_q <= data_i;
          end else if (accept) begin
            skid_q  <= data_i;
            state_q <= FULL;
            ready_q <= 1'b0;
          end else if (drain) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            main_q  <= skid_q;
            state_q <= BUSY;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

`else

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             accept;

  assign ready_o = !valid_q || ready_i;
  assign accept  = valid_i && ready_o && !flush_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Flush clears only the valid bit; stale data is harmless once invalid.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

`endif

endmodule

// File: rtl/pipe_reg_slice.sv
// DEPTH-stage valid/ready pipeline register with flush and occupancy count.
// Optional PIPE_SKID_EN gives skid-buffered stages (capacity 2*DEPTH, registered in_ready).
module pipe_reg_slice
  import pipe_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int CAP   = DEPTH * ENTRIES_PER_STAGE,
  localparam int CNT_W = calcCntW(CAP)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             softReset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy
);

  logic [DEPTH:0]   vldChain;
  logic [DEPTH:0]   rdyChain;
  logic [WIDTH-1:0] dataChain [DEPTH+1];
  logic             inAccept;
  logic             outAccept;
  logic [CNT_W-1:0] occ_q, occ_d;

  assign vldChain[0]     = in_valid;
  assign dataChain[0]    = in_data;
  assign rdyChain[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : gStage
    pipe_stage #(.WIDTH(WIDTH)) uStage (
      .clk_i   (clk),
      .rst_ni  (reset),
      .flush_i (softReset),
      .valid_i (vldChain[i]),
      .data_i  (dataChain[i]),
      .ready_o (rdyChain[i]),
      .valid_o (vldChain[i+1]),
      .data_o  (dataChain[i+1]),
      .ready_i (rdyChain[i+1])
    );
  end

  // During a flush the input is swallowed, so advertise ready to keep upstream moving.
  assign in_ready  = softReset || rdyChain[0];
  assign out_valid = vldChain[DEPTH];
  assign out_data  = dataChain[DEPTH];

  assign inAccept  = in_valid && in_ready && !softReset;
  assign outAccept = out_valid && out_ready;

  always_comb begin
    occ_d = occ_q;
    if (softReset) begin
      occ_d = '0;
    end else if (inAccept && !outAccept) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (outAccept && !inAccept) begin
      occ_d = occ_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule
